// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan controller: segment ROM and idle patterns.
// Segment patterns are active-low, bit order g..a.
package fnd_pkg;

  localparam logic [3:0] FND_OFF   = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digits 0-9, hex letters A b C d E; nibble F renders blank
  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, SEG_BLANK
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble to 7-segment decoder (active-low, g..a).
module bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // ROM lookup of the segment pattern
  always_comb begin
    seg = SEG_LUT[nib];
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode FND driver with frame-coherent paging,
// steady/blinking decimal point and whole-display blanking.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] bcd,
  input  logic        page,
  input  logic        dp_en,
  input  logic        dp_blink,
  input  logic [1:0]  dp_pos,
  input  logic        blank,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data
);

  localparam int SCAN_DIV  = SYS_CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = SYS_CLK_HZ / (2 * BLINK_HZ);
  localparam int SCW       = $clog2(SCAN_DIV);
  localparam int BKW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
  localparam logic [BKW-1:0] BLINK_LAST = BKW'(BLINK_DIV - 1);

  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BKW-1:0] blk_cnt_q, blk_cnt_d;
  logic           dp_phase_q, dp_phase_d;
  logic [1:0]     dig_q, dig_d;
  logic [23:0]    snap_q, snap_d;
  logic           pg_q, pg_d;
  logic [3:0]     com_q, com_d;
  logic [7:0]     data_q, data_d;

  logic           tick_s;
  logic [1:0]     nxt_s;
  logic [23:0]    src_word_s;
  logic           src_pg_s;
  logic [15:0]    window_s;
  logic [3:0]     nib_s;
  logic [6:0]     seg_s;
  logic           dp_lit_s;

  // Select the nibble for the upcoming digit; digit 0 reads the live word
  // so a frame-start snapshot and its first digit always agree.
  always_comb begin
    tick_s = (scan_cnt_q == SCAN_LAST);
    nxt_s  = dig_q + 2'd1;
    if (nxt_s == 2'd0) begin
      src_word_s = bcd;
      src_pg_s   = page;
    end else begin
      src_word_s = snap_q;
      src_pg_s   = pg_q;
    end
    if (src_pg_s) begin
      window_s = src_word_s[23:8];
    end else begin
      window_s = src_word_s[15:0];
    end
    nib_s    = window_s[{nxt_s, 2'b00} +: 4];
    dp_lit_s = dp_en && (nxt_s == dp_pos) && (!dp_blink || dp_phase_q);
  end

  bcd_to_seg u_dec (
    .nib (nib_s),
    .seg (seg_s)
  );

  // Next-state: prescaler, free-running blink timer, digit step and outputs
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    dp_phase_d = dp_phase_q;
    dig_d      = dig_q;
    snap_d     = snap_q;
    pg_d       = pg_q;
    com_d      = com_q;
    data_d     = data_q;

    if (blk_cnt_q == BLINK_LAST) begin
      blk_cnt_d  = '0;
      dp_phase_d = ~dp_phase_q;
    end else begin
      blk_cnt_d  = blk_cnt_q + BKW'(1);
      dp_phase_d = dp_phase_q;
    end

    if (tick_s) begin
      scan_cnt_d = '0;
      dig_d      = nxt_s;
      if (nxt_s == 2'd0) begin
        snap_d = bcd;
        pg_d   = page;
      end else begin
        snap_d = snap_q;
        pg_d   = pg_q;
      end
      if (blank) begin
        com_d = FND_OFF;
      end else begin
        com_d = ~(4'b0001 << nxt_s);
      end
      data_d = {~dp_lit_s, seg_s};
    end else begin
      scan_cnt_d = scan_cnt_q + SCW'(1);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q <= '0;
      blk_cnt_q  <= '0;
      dp_phase_q <= 1'b0;
      dig_q      <= 2'd3;
      snap_q     <= 24'h000000;
      pg_q       <= 1'b0;
      com_q      <= FND_OFF;
      data_q     <= 8'hFF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      dp_phase_q <= dp_phase_d;
      dig_q      <= dig_d;
      snap_q     <= snap_d;
      pg_q       <= pg_d;
      com_q      <= com_d;
      data_q     <= data_d;
    end
  end

  assign fnd_com  = com_q;
  assign fnd_data = data_q;

endmodule
